// File: rtl/syzygy_adc_word_align.sv
// syzygy_adc_word_align
//   Takes the raw 8-bit ISERDES words of the two data lanes of one ADC channel.
//   It applies the frame stage's bitslip count as a bit-window shift and
//   interleaves the lanes into a 16-bit sample. Samples are queued in a small
//   first-word-fall-through FIFO that faces the capture logic with valid/ready.
// Ports
//   slow_clk       divided decode clock, single clock domain
//   reset          asynchronous, active-high
//   data_valid     frame alignment settled
//   bitslip_count  bit offset 0..7 (values above 7 are flagged, not used)
//   lane_a/lane_b  lane A carries odd sample bits, lane B carries even sample bits
//   m_data/m_valid/m_ready  sample stream out, transfer on m_valid & m_ready
//   overflow       sticky, a sample was dropped on a full FIFO
//   align_err      sticky, illegal bitslip_count while data_valid was high
//   sample_count   samples accepted into the FIFO, wraps
module syzygy_adc_word_align #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int FLUSH_CYC  = 2
) (
  input  logic             slow_clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [3:0]       bitslip_count,
  input  logic [7:0]       lane_a,
  input  logic [7:0]       lane_b,
  output logic [15:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overflow,
  output logic             align_err,
  output logic [CNT_W-1:0] sample_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int FL_W  = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  // Window of 8 bits starting s bits up from the LSB of {prev, cur}.
  function automatic logic [7:0] align_window(input logic [7:0] prev,
                                              input logic [7:0] cur,
                                              input logic [2:0] s);
    logic [15:0] w;
    w = {prev, cur} >> s;
    return w[7:0];
  endfunction

  function automatic logic [15:0] interleave(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = a[i];
      r[2*i]   = b[i];
    end
    return r;
  endfunction

  logic [7:0]  cur_a_p1, cur_b_p1, prev_a_p1, prev_b_p1;
  logic [2:0]  s_p1;
  logic        vld_p1, restart_p1;
  logic [7:0]  al_a_p2, al_b_p2;
  logic        vld_p2, restart_p2;
  logic [15:0] sample_p3;
  logic        vld_p3, restart_p3;
  logic [FL_W-1:0] flush_cnt;

  logic v1_in, restart_in;
  // A restart marks the first sample after valid rises or the slip moves;
  // it travels with the data so the flush discards exactly the affected samples.
  assign v1_in      = data_valid & (bitslip_count <= 4'd7);
  assign restart_in = v1_in & (~vld_p1 | (bitslip_count[2:0] != s_p1));

  // ---- stage 1: capture lane words, slip and qualifier ----
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      cur_a_p1   <= '0;
      cur_b_p1   <= '0;
      prev_a_p1  <= '0;
      prev_b_p1  <= '0;
      s_p1       <= '0;
      vld_p1     <= 1'b0;
      restart_p1 <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      cur_a_p1   <= lane_a;
      cur_b_p1   <= lane_b;
      prev_a_p1  <= cur_a_p1;
      prev_b_p1  <= cur_b_p1;
      s_p1       <= bitslip_count[2:0];
      vld_p1     <= v1_in;
      restart_p1 <= restart_in;
      if (data_valid && (bitslip_count > 4'd7)) align_err <= 1'b1;
    end
  end

  // ---- stage 2: bit-window alignment ----
  always_ff @(posedge slow_clk) begin
    al_a_p2 <= align_window(prev_a_p1, cur_a_p1, s_p1);
    al_b_p2 <= align_window(prev_b_p1, cur_b_p1, s_p1);
  end

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      vld_p2     <= 1'b0;
      restart_p2 <= 1'b0;
    end else begin
      vld_p2     <= vld_p1;
      restart_p2 <= restart_p1 & vld_p1;
    end
  end

  // ---- stage 3: interleave, flush gating, FIFO push ----
  always_ff @(posedge slow_clk) begin
    sample_p3 <= interleave(al_a_p2, al_b_p2);
  end

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      vld_p3     <= 1'b0;
      restart_p3 <= 1'b0;
    end else begin
      vld_p3     <= vld_p2;
      restart_p3 <= restart_p2 & vld_p2;
    end
  end

  logic push_req;
  always_comb begin
    push_req = 1'b0;
    if (vld_p3) begin
      if (restart_p3) push_req = (FLUSH_CYC == 0);
      else            push_req = (flush_cnt == '0);
    end
  end

  // The restart sample itself is the first discarded one, so the reload
  // lands at FLUSH_CYC-1 to drop FLUSH_CYC samples in total.
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= FL_W'(FLUSH_CYC);
    end else if (vld_p3) begin
      if (restart_p3)            flush_cnt <= FL_W'((FLUSH_CYC == 0) ? 0 : FLUSH_CYC - 1);
      else if (flush_cnt != '0)  flush_cnt <= flush_cnt - FL_W'(1);
    end
  end

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & m_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  assign m_valid = ~empty;
  assign m_data  = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge slow_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= sample_p3;
  end

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        sample_count <= sample_count + CNT_W'(1);
      end
      if (pop)  rd_ptr   <= rd_ptr + PTR_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syzygy_adc_word_align.sv
module tb_syzygy_adc_word_align;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 32;
  localparam int FLUSH_CYC  = 2;

  logic             slow_clk = 1'b0;
  logic             reset;
  logic             data_valid;
  logic [3:0]       bitslip_count;
  logic [7:0]       lane_a, lane_b;
  logic [15:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic             overflow, align_err;
  logic [CNT_W-1:0] sample_count;

  syzygy_adc_word_align #(
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .slow_clk(slow_clk), .reset(reset), .data_valid(data_valid),
    .bitslip_count(bitslip_count), .lane_a(lane_a), .lane_b(lane_b),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .align_err(align_err), .sample_count(sample_count)
  );

  always #5 slow_clk = ~slow_clk;

  logic [15:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  logic [7:0]  last_a = 8'h00;
  logic [7:0]  last_b = 8'h00;

  // Reference: bit i of the aligned word is bit (s+i) of the 16-bit {prev,cur}.
  function automatic logic [7:0] ref_align(input logic [7:0] prev, input logic [7:0] cur,
                                           input logic [2:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = i + int'(s);
      r[i] = (idx < 8) ? cur[idx] : prev[idx-8];
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_sample(input logic [7:0] pa, input logic [7:0] ca,
                                             input logic [7:0] pb, input logic [7:0] cb,
                                             input logic [2:0] s);
    logic [7:0]  aa, bb;
    logic [15:0] r;
    aa = ref_align(pa, ca, s);
    bb = ref_align(pb, cb, s);
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = aa[i];
      r[2*i]   = bb[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0: no sample expected, 1: model value expected, 2: explicit value expected
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] slip,
                      input logic dv, input int mode, input logic [15:0] val);
    lane_a = a; lane_b = b; bitslip_count = slip; data_valid = dv;
    if (mode == 1) begin
      sb.push_back(ref_sample(last_a, a, last_b, b, slip[2:0]));
      exp_count++;
    end else if (mode == 2) begin
      sb.push_back(val);
      exp_count++;
    end
    last_a = a; last_b = b;
    @(posedge slow_clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 8'h00, 4'd0, 1'b0, 0, 16'h0);
  endtask

  // A run of n words at one slip; the first FLUSH_CYC are flushed by the DUT.
  task automatic run_words(input logic [3:0] slip, input int n, input int base);
    for (int k = 0; k < n; k++)
      step(8'(base * 37 + k * 91 + 5), 8'((base * 13) ^ (k * 53 + 3)), slip, 1'b1,
           (k >= FLUSH_CYC) ? 1 : 0, 16'h0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge slow_clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d samples still pending, required 0", name, sb.size());
    end
  endtask

  // Monitor: any presented-and-accepted sample must match the scoreboard head.
  always @(negedge slow_clk) begin
    if (reset === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_sample: got %h with no sample required", m_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (m_data !== e) begin
          fails++;
          $display("FAIL sample_data: got %h required %h", m_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; data_valid = 1'b0; bitslip_count = 4'd0;
    lane_a = 8'h00; lane_b = 8'h00; m_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_sample_count", sample_count, 32'd0);
    @(posedge slow_clk); @(posedge slow_clk); #1;
    reset = 1'b0;
    idle(2);

    // Constant F0/0F at s=0 interleaves to AA55 once the flush is over.
    for (int k = 0; k < 10; k++)
      step(8'hF0, 8'h0F, 4'd0, 1'b1, (k >= FLUSH_CYC) ? 2 : 0, 16'hAA55);
    idle(1);

    // Hand vector at s=3: prev 7E, cur 81 gives al_a = D0, al_b = 00 -> A200.
    step(8'h00, 8'h00, 4'd3, 1'b1, 0, 16'h0);
    step(8'h11, 8'h00, 4'd3, 1'b1, 0, 16'h0);
    step(8'h7E, 8'h00, 4'd3, 1'b1, 1, 16'h0);
    step(8'h81, 8'h00, 4'd3, 1'b1, 2, 16'hA200);
    idle(1);

    // All slips against the bitwise model.
    for (int s = 0; s < 8; s++) begin
      run_words(4'(s), 5, s + 1);
      idle(1);
    end
    idle(5);
    wait_drain("drain_sweep");
    chk("count_sweep", sample_count, 32'(exp_count));

    // Mid-stream slip change 2 -> 5 without dropping data_valid.
    run_words(4'd2, 6, 20);
    run_words(4'd5, 6, 21);
    idle(6);
    wait_drain("drain_slip_change");
    chk("count_slip_change", sample_count, 32'(exp_count));
    chk("overflow_still_clear", 32'(overflow), 32'd0);

    // Stall the consumer for FIFO_DEPTH+3 samples: 8 held, 3 dropped.
    m_ready = 1'b0;
    for (int k = 0; k < FLUSH_CYC + FIFO_DEPTH + 3; k++)
      step(8'(k * 29 + 1), 8'(k * 17 + 9), 4'd1, 1'b1,
           (k >= FLUSH_CYC && k < FLUSH_CYC + FIFO_DEPTH) ? 1 : 0, 16'h0);
    idle(6);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_count", sample_count, 32'(exp_count));
    chk("full_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_drain("drain_full");
    chk("drained_m_valid", 32'(m_valid), 32'd0);

    // Illegal slip: flagged, nothing pushed, flag survives a legal slip.
    for (int k = 0; k < 5; k++) step(8'(k + 40), 8'(k + 50), 4'd9, 1'b1, 0, 16'h0);
    idle(5);
    chk("bad_slip_align_err", 32'(align_err), 32'd1);
    chk("bad_slip_no_push", sample_count, 32'(exp_count));
    chk("bad_slip_m_valid", 32'(m_valid), 32'd0);
    step(8'h3C, 8'hC3, 4'd9, 1'b1, 0, 16'h0);
    run_words(4'd0, 4, 30);
    idle(5);
    wait_drain("drain_after_bad_slip");
    chk("align_err_sticky", 32'(align_err), 32'd1);
    chk("count_after_bad_slip", sample_count, 32'(exp_count));

    // Half-full FIFO, then asynchronous reset between clock edges.
    m_ready = 1'b0;
    run_words(4'd0, FLUSH_CYC + FIFO_DEPTH / 2, 40);
    idle(5);
    chk("half_full_m_valid", 32'(m_valid), 32'd1);
    chk("half_full_count", sample_count, 32'(exp_count));
    #2 reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_align_err", 32'(align_err), 32'd0);
    chk("async_rst_count", sample_count, 32'd0);
    chk("async_rst_m_data", 32'(m_data), 32'd0);
    @(posedge slow_clk); @(posedge slow_clk); #1;
    reset = 1'b0;
    exp_count = 0;
    m_ready = 1'b1;
    last_a = 8'h00; last_b = 8'h00;

    // Normal operation resumes after reset.
    run_words(4'd6, 6, 50);
    idle(6);
    wait_drain("drain_post_reset");
    chk("count_post_reset", sample_count, 32'(exp_count));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
